affine_sbox_seq: RTL
====================

# affine_sbox_seq

Multi-cycle forward AES S-box for the encrypt datapath. It is the counterpart of the inverse-affine/decrypt path. It accepts one byte over a valid/ready handshake and computes the GF(2^8) multiplicative inverse x^254 by iterative square-and-multiply. It then applies the FIPS 197 forward affine transform and presents the result over a second valid/ready handshake. It sits between the state register and the ShiftRows stage in area-constrained builds where a combinational S-box is too large.

## Interface
- No parameters. Field polynomial 0x11B and affine constant 0x63 are fixed.
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte_in holds a byte to substitute.
- in_ready  out  1  block can accept a byte this cycle.
- byte_in  in  8  input byte; sampled only on accept.
- out_valid  out  1  byte_out holds a finished S-box result.
- out_ready  in  1  downstream consumes byte_out this cycle.
- byte_out  out  8  S-box result; forced to 8'h00 whenever out_valid=0.

## Operation
- Registers:
  - state: IDLE, MUL, FIN, OUT.
  - x: 8-bit captured input.
  - r: 8-bit accumulator.
  - cnt: 3-bit counter.
  - res: 8-bit result.
- in_ready = (state==IDLE). out_valid = (state==OUT). byte_out = out_valid ? res : 8'h00.
- IDLE: on in_valid && in_ready, set x<=byte_in and r<=byte_in, cnt<=0, go to MUL. Otherwise stay.
- MUL: r <= gmul(gsq(r), x); cnt<=cnt+1. When cnt==5, go to FIN. After 6 updates r = x^127.
- FIN: res <= aff(gsq(r)), where gsq(r)=x^254. Go to OUT.
- OUT: hold res. On out_ready, go to IDLE.
- gmul: GF(2^8) product modulo x^8+x^4+x^3+x+1. gsq(a)=gmul(a,a). All intermediates are 8 bits wide after reduction.
- Zero input: 0^254 = 0 falls out naturally, with no special case. aff(0)=0x63.
- aff(b)[i] = b[i]^b[(i+4)%8]^b[(i+5)%8]^b[(i+6)%8]^b[(i+7)%8]^c[i], with c=8'h63.
- While not IDLE, in_valid is ignored and byte_in changes have no effect on the result in flight.
- The upstream must hold byte_in stable only in the accept cycle.

## Timing
- Reset (asserted asynchronously at any time, including mid-computation or while OUT is stalled):
  - state=IDLE, x=r=res=0, cnt=0.
  - in_ready=1, out_valid=0, byte_out=0x00.
  - The in-flight byte is discarded; no partial result appears after release.
- Latency:
  - Accept at edge E0.
  - MUL updates at E1..E6; FIN at E7.
  - out_valid=1 after E7, i.e. 7 cycles after the accept edge.
- Handshake:
  - Output transfer occurs on the edge where out_valid && out_ready. in_ready rises after that edge.
  - Minimum spacing is 9 cycles between consecutive accepts when out_ready is held high.
  - out_valid and byte_out stay stable under out_ready=0 for any number of cycles.
- Outputs are all functions of registered state only; no combinational path from in_valid or out_ready to any output.
- Simultaneous in_valid=1 while in OUT with out_ready=1: the output transfers and nothing is accepted that cycle. The new byte is accepted on the following cycle in IDLE.

## Test plan
- Reset, then drive byte_in=0x00 and in_valid=1 for one cycle, with out_ready=1 -> out_valid rises 7 cycles after accept with byte_out=0x63. Also check byte_out=0x00 before that point.
- Directed vectors 0x01 -> 0x7C, 0x53 -> 0xED, 0xFF -> 0x16, 0x10 -> 0xCA, each checked for exact 7-cycle latency.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid rises on input 0x53 -> byte_out stays 0xED and in_ready stays 0. Pulsing in_valid with 0xAA during the stall has no effect. Releasing out_ready gives one transfer, then in_ready=1 next cycle.
- Reset mid-operation: assert reset_n=0 during MUL (cnt=3) and, separately, during a stalled OUT -> immediately out_valid=0 and byte_out=0x00. After release in_ready=1 and no spurious out_valid. A following 0x01 yields 0x7C.
- Exhaustive: stream all 256 inputs back-to-back with in_valid and out_ready held high -> results match the FIPS 197 S-box table. Inputs are accepted exactly every 9 cycles.
- Input stability: change byte_in every cycle after accept -> result depends only on the byte sampled at the accept edge.

Source files
------------

// File: rtl/affine_sbox_seq_if.sv
// ---------------------------------------------------------------------------
// affine_sbox_seq_if
// Handshake bundle for the multi-cycle forward AES S-box.
//   in_valid  : upstream presents byte_in
//   in_ready  : S-box can accept a byte this cycle
//   byte_in   : byte to substitute, sampled on accept
//   out_valid : byte_out holds a finished S-box result
//   out_ready : downstream consumes byte_out this cycle
//   byte_out  : S-box result, 8'h00 whenever out_valid is low
// The S-box itself connects through the slave modport; the side that feeds
// bytes in and takes results out uses the master modport.
// ---------------------------------------------------------------------------
interface affine_sbox_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] byte_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] byte_out;

  modport slave (
    input  in_valid,
    input  byte_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output byte_out
  );

  modport master (
    output in_valid,
    output byte_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  byte_out
  );
endinterface

// File: rtl/affine_sbox_seq.sv
// ---------------------------------------------------------------------------
// affine_sbox_seq
// Multi-cycle forward AES S-box. A byte accepted over the input handshake is
// inverted in GF(2^8) (x^254 via six square-and-multiply steps plus a final
// square), passed through the FIPS 197 forward affine transform and presented
// over the output handshake.
// Ports:
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : affine_sbox_seq_if.slave (in_valid/in_ready/byte_in,
//             out_valid/out_ready/byte_out)
// Latency is 7 cycles from the accept edge to out_valid; with out_ready held
// high, consecutive accepts are 9 cycles apart.
// ---------------------------------------------------------------------------
module affine_sbox_seq (
  input  logic              clk,
  input  logic              reset_n,
  affine_sbox_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_x;
  logic [7:0] r_r;
  logic [2:0] r_cnt;
  logic [7:0] r_res;

  // GF(2^8) product modulo x^8+x^4+x^3+x+1 (shift-and-add, reduce each step)
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] gsq(input logic [7:0] a);
    return gmul(a, a);
  endfunction

  // Forward affine: b[i]^b[i+4]^b[i+5]^b[i+6]^b[i+7] (mod 8) is b XOR its
  // left rotations by 1..4, then the constant 0x63.
  function automatic logic [7:0] aff(input logic [7:0] b);
    logic [7:0] rl1;
    logic [7:0] rl2;
    logic [7:0] rl3;
    logic [7:0] rl4;
    rl1 = {b[6:0], b[7]};
    rl2 = {b[5:0], b[7:6]};
    rl3 = {b[4:0], b[7:5]};
    rl4 = {b[3:0], b[7:4]};
    return b ^ rl1 ^ rl2 ^ rl3 ^ rl4 ^ 8'h63;
  endfunction

  // Outputs depend on registered state only
  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.byte_out  = (r_state == S_OUT) ? r_res : 8'h00;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.in_valid) w_state_nxt = S_MUL;
      S_MUL:  if (r_cnt == 3'd5) w_state_nxt = S_FIN;
      S_FIN:  w_state_nxt = S_OUT;
      S_OUT:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: r walks x^3, x^7, ... x^127 over six MUL cycles; FIN squares
  // once more to reach x^254 = x^-1 (and 0 stays 0 with no special case).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x   <= 8'h00;
      r_r   <= 8'h00;
      r_cnt <= 3'd0;
      r_res <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x   <= bus.byte_in;
            r_r   <= bus.byte_in;
            r_cnt <= 3'd0;
          end
        end
        S_MUL: begin
          r_r   <= gmul(gsq(r_r), r_x);
          r_cnt <= r_cnt + 3'd1;
        end
        S_FIN: begin
          r_res <= aff(gsq(r_r));
        end
        default: ;
      endcase
    end
  end

endmodule
